// File: rtl/pal_access_sched_if.sv
// Bundle of the video, CPU and palette-RAM signals that pal_access_sched arbitrates.
// The slave modport is the scheduler; the master modport is its surroundings.
interface pal_access_sched_if;
  logic        vid_req;
  logic [12:0] vid_addr;
  logic [15:0] vid_dout;
  logic        vid_valid;

  logic        cpu_req;
  logic        cpu_we;
  logic [12:0] cpu_addr;
  logic [15:0] cpu_din;
  logic [15:0] cpu_dout;
  logic        cpu_ack;
  logic        cpu_wait;

  logic [12:0] pal_addr;
  logic        pal_we;
  logic [15:0] pal_dout;
  logic [15:0] pal_din;

  modport slave (
    input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, pal_din,
    output vid_dout, vid_valid, cpu_dout, cpu_ack, cpu_wait, pal_addr, pal_we, pal_dout
  );

  modport master (
    output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_din, pal_din,
    input  vid_dout, vid_valid, cpu_dout, cpu_ack, cpu_wait, pal_addr, pal_we, pal_dout
  );
endinterface

// File: rtl/pal_access_sched.sv
// Fixed-slot palette RAM scheduler: 8-cycle frame on clk_24m, video slot P0-P1, CPU slot P4-P5,
// plus 12M/6M/3M enable strobes. Define PAL_SCHED_CPU_FILL_EN to let the CPU use idle video slots.
//
// state    | meaning
// ST_IDLE  | no RAM access in progress
// ST_VID   | video read in progress (P0-P1)
// ST_CPU   | CPU access in progress (P4-P5, or P0-P1 when filling an idle video slot)
module pal_access_sched (
  input  logic                      clk_24m,
  input  logic                      reset,
  pal_access_sched_if.slave         bus,
  output logic                      ce_12m,
  output logic                      ce_6m,
  output logic                      ce_3m
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_VID  = 2'd1;
  localparam logic [1:0] ST_CPU  = 2'd2;

  logic [2:0]  p_q, p_d;
  logic [1:0]  state_q, state_d;
  logic        ce_12m_q, ce_12m_d;
  logic        ce_6m_q, ce_6m_d;
  logic        ce_3m_q, ce_3m_d;
  logic [12:0] pal_addr_q, pal_addr_d;
  logic        pal_we_q, pal_we_d;
  logic [15:0] pal_dout_q, pal_dout_d;
  logic [15:0] vid_dout_q, vid_dout_d;
  logic        vid_valid_q, vid_valid_d;
  logic [15:0] cpu_dout_q, cpu_dout_d;
  logic        cpu_ack_q, cpu_ack_d;

  always_comb begin
    p_d         = p_q + 3'd1;
    // strobes are computed from the next phase so they are high while P holds that value
    ce_12m_d    = p_d[0];
    ce_6m_d     = (p_d[1:0] == 2'b11);
    ce_3m_d     = (p_d == 3'd7);

    state_d     = state_q;
    pal_addr_d  = pal_addr_q;
    pal_we_d    = pal_we_q;
    pal_dout_d  = pal_dout_q;
    vid_dout_d  = vid_dout_q;
    vid_valid_d = 1'b0;
    cpu_dout_d  = cpu_dout_q;
    cpu_ack_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (p_q == 3'd7 && bus.vid_req) begin
          state_d    = ST_VID;
          pal_addr_d = bus.vid_addr;
          pal_we_d   = 1'b0;
`ifdef PAL_SCHED_CPU_FILL_EN
        end else if (p_q == 3'd7 && bus.cpu_req) begin
          state_d    = ST_CPU;
          pal_addr_d = bus.cpu_addr;
          pal_dout_d = bus.cpu_din;
          pal_we_d   = bus.cpu_we;
`endif
        end else if (p_q == 3'd3 && bus.cpu_req) begin
          state_d    = ST_CPU;
          pal_addr_d = bus.cpu_addr;
          pal_dout_d = bus.cpu_din;
          pal_we_d   = bus.cpu_we;
        end
      end
      ST_VID: begin
        if (p_q == 3'd1) begin
          state_d     = ST_IDLE;
          vid_dout_d  = bus.pal_din;
          vid_valid_d = 1'b1;
        end
      end
      ST_CPU: begin
        // a CPU slot always ends after its second cycle (P1 or P5)
        if (p_q[1:0] == 2'b01) begin
          state_d   = ST_IDLE;
          pal_we_d  = 1'b0;
          cpu_ack_d = 1'b1;
          if (!pal_we_q) begin
            cpu_dout_d = bus.pal_din;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        pal_we_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_24m) begin
    if (reset) begin
      p_q         <= 3'b100;
      state_q     <= ST_IDLE;
      ce_12m_q    <= 1'b0;
      ce_6m_q     <= 1'b0;
      ce_3m_q     <= 1'b0;
      pal_addr_q  <= 13'd0;
      pal_we_q    <= 1'b0;
      pal_dout_q  <= 16'd0;
      vid_dout_q  <= 16'd0;
      vid_valid_q <= 1'b0;
      cpu_dout_q  <= 16'd0;
      cpu_ack_q   <= 1'b0;
    end else begin
      p_q         <= p_d;
      state_q     <= state_d;
      ce_12m_q    <= ce_12m_d;
      ce_6m_q     <= ce_6m_d;
      ce_3m_q     <= ce_3m_d;
      pal_addr_q  <= pal_addr_d;
      pal_we_q    <= pal_we_d;
      pal_dout_q  <= pal_dout_d;
      vid_dout_q  <= vid_dout_d;
      vid_valid_q <= vid_valid_d;
      cpu_dout_q  <= cpu_dout_d;
      cpu_ack_q   <= cpu_ack_d;
    end
  end

  assign ce_12m        = ce_12m_q;
  assign ce_6m         = ce_6m_q;
  assign ce_3m         = ce_3m_q;
  assign bus.pal_addr  = pal_addr_q;
  assign bus.pal_we    = pal_we_q;
  assign bus.pal_dout  = pal_dout_q;
  assign bus.vid_dout  = vid_dout_q;
  assign bus.vid_valid = vid_valid_q;
  assign bus.cpu_dout  = cpu_dout_q;
  assign bus.cpu_ack   = cpu_ack_q;
  assign bus.cpu_wait  = bus.cpu_req & ~cpu_ack_q;

endmodule
